// File: rtl/round_sequencer.sv
// Sequencing controller for the 16-bit round-up datapath: handshakes samples in, completes
// the carry into a[15:12] when needed, and handshakes results out. Optional counters: ROUND_STATS_EN.
`timescale 1ns/1ps
module round_sequencer #(
   parameter int CNT_W     = 16,
   parameter bit CARRY_SAT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      in_data,
   input  logic             in_round,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      dp_a,
   output logic             dp_dog,
   input  logic [15:0]      dp_mag,
   input  logic             dp_feeder,
   output logic [15:0]      out_data,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] stat_rnd,
   output logic [CNT_W-1:0] stat_ovf
);

   typedef enum logic [1:0] {IDLE, ISSUE, CARRY, HOLD} state_t;

   state_t      state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic [15:0] dp_a_q, dp_a_d;
   logic        dp_dog_q, dp_dog_d;
   logic [15:0] out_data_q, out_data_d;
   logic        out_ovf_q, out_ovf_d;
   logic        out_valid_q, out_valid_d;
   logic        capture;
   logic        hold_entry;

   always_comb begin
      state_d    = state_q;
      dp_a_d     = dp_a_q;
      dp_dog_d   = dp_dog_q;
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
      capture    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               capture  = 1'b1;
               dp_a_d   = in_data;
               dp_dog_d = in_round;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (dp_feeder) begin
               state_d = CARRY;
            end else begin
               out_data_d = dp_mag;
               out_ovf_d  = 1'b0;
               state_d    = HOLD;
            end
         end
         CARRY: begin
            // The nibble below overflowed; ripple the carry into the top nibble.
            if (dp_a_q[15:12] != 4'hF) begin
               out_data_d = {dp_a_q[15:12] + 4'd1, 12'd0};
               out_ovf_d  = 1'b0;
            end else begin
               out_data_d = CARRY_SAT ? 16'hFFFF : 16'h0000;
               out_ovf_d  = 1'b1;
            end
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == HOLD);
      hold_entry  = (state_q != HOLD) && (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         dp_a_q      <= 16'd0;
         dp_dog_q    <= 1'b0;
         out_data_q  <= 16'd0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         dp_a_q      <= dp_a_d;
         dp_dog_q    <= dp_dog_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign dp_a      = dp_a_q;
   assign dp_dog    = dp_dog_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;
   assign out_valid = out_valid_q;

`ifdef ROUND_STATS_EN
   logic [CNT_W-1:0] stat_rnd_q, stat_rnd_d;
   logic [CNT_W-1:0] stat_ovf_q, stat_ovf_d;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      stat_rnd_d = stat_rnd_q;
      stat_ovf_d = stat_ovf_q;
      if (capture && in_round && (stat_rnd_q != {CNT_W{1'b1}})) begin
         stat_rnd_d = stat_rnd_q + 1'b1;
      end
      if (hold_entry && out_ovf_d && (stat_ovf_q != {CNT_W{1'b1}})) begin
         stat_ovf_d = stat_ovf_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_rnd_q <= '0;
         stat_ovf_q <= '0;
      end else begin
         stat_rnd_q <= stat_rnd_d;
         stat_ovf_q <= stat_ovf_d;
      end
   end

   assign stat_rnd = stat_rnd_q;
   assign stat_ovf = stat_ovf_q;
`else
   logic unused_stats;
   assign unused_stats = capture ^ hold_entry;
   assign stat_rnd     = '0;
   assign stat_ovf     = '0;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Directed self-checking bench for round_sequencer; a saturating and a wrapping instance
// share stimulus, each with its own behavioural datapath model.
`timescale 1ns/1ps
module tb_round_sequencer;

`ifdef ROUND_STATS_EN
   localparam int CW = 2;
`else
   localparam int CW = 16;
`endif

   logic          clk;
   logic          rst_n;
   logic [15:0]   in_data;
   logic          in_round;
   logic          in_valid;
   logic          out_ready;

   logic          s_in_ready, w_in_ready;
   logic [15:0]   s_dp_a, w_dp_a;
   logic          s_dp_dog, w_dp_dog;
   logic [15:0]   s_dp_mag, w_dp_mag;
   logic          s_dp_feeder, w_dp_feeder;
   logic [15:0]   s_out_data, w_out_data;
   logic          s_out_ovf, w_out_ovf;
   logic          s_out_valid, w_out_valid;
   logic [CW-1:0] s_stat_rnd, w_stat_rnd;
   logic [CW-1:0] s_stat_ovf, w_stat_ovf;

   int compared;
   int mismatched;

   // Round-up datapath: bump a[11:8], clear the low byte; feeder flags a[11:8] overflow.
   assign s_dp_mag    = s_dp_dog ? {s_dp_a[15:12], s_dp_a[11:8] + 4'd1, 8'h00} : s_dp_a;
   assign s_dp_feeder = s_dp_dog && (s_dp_a[11:8] == 4'hF);
   assign w_dp_mag    = w_dp_dog ? {w_dp_a[15:12], w_dp_a[11:8] + 4'd1, 8'h00} : w_dp_a;
   assign w_dp_feeder = w_dp_dog && (w_dp_a[11:8] == 4'hF);

   round_sequencer #(.CNT_W(CW), .CARRY_SAT(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_round(in_round), .in_valid(in_valid), .in_ready(s_in_ready),
      .dp_a(s_dp_a), .dp_dog(s_dp_dog), .dp_mag(s_dp_mag), .dp_feeder(s_dp_feeder),
      .out_data(s_out_data), .out_ovf(s_out_ovf), .out_valid(s_out_valid), .out_ready(out_ready),
      .stat_rnd(s_stat_rnd), .stat_ovf(s_stat_ovf)
   );

   round_sequencer #(.CNT_W(CW), .CARRY_SAT(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_round(in_round), .in_valid(in_valid), .in_ready(w_in_ready),
      .dp_a(w_dp_a), .dp_dog(w_dp_dog), .dp_mag(w_dp_mag), .dp_feeder(w_dp_feeder),
      .out_data(w_out_data), .out_ovf(w_out_ovf), .out_valid(w_out_valid), .out_ready(out_ready),
      .stat_rnd(w_stat_rnd), .stat_ovf(w_stat_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample, wait for the accept edge, then count cycles until out_valid.
   task automatic run_sample(input logic [15:0] d, input logic r, output int lat);
      int n;
      in_data  = d;
      in_round = r;
      in_valid = 1'b1;
      n = 0;
      while (!s_in_ready && n < 8) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!s_out_valid && lat < 10) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      compared++;
      if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0 || s_out_ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: ready=%b valid=%b ovf=%b, want 0 0 0", s_in_ready, s_out_valid, s_out_ovf);
      end
      compared++;
      if (s_out_data !== 16'h0000 || s_dp_a !== 16'h0000 || s_dp_dog !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_data: out=%h dp_a=%h dog=%b, want 0000 0000 0", s_out_data, s_dp_a, s_dp_dog);
      end
      compared++;
      if (s_stat_rnd !== '0 || s_stat_ovf !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_stats: rnd=%0d ovf=%0d, want 0 0", s_stat_rnd, s_stat_ovf);
      end
      rst_n = 1'b1;
      tick();
      compared++;
      if (s_in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL idle_ready: got %b, want 1", s_in_ready);
      end
   endtask

   task automatic test_pass_through();
      int lat;
      run_sample(16'hABCD, 1'b0, lat);
      compared++;
      if (lat !== 2) begin
         mismatched++;
         $display("[TB] FAIL pass_latency: got %0d, want 2", lat);
      end
      compared++;
      if (s_out_data !== 16'hABCD || s_out_ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL pass_data: got %h/%b, want abcd/0", s_out_data, s_out_ovf);
      end
      compared++;
      if (s_dp_a !== 16'hABCD || s_dp_dog !== 1'b0 || s_in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL pass_dp: dp_a=%h dog=%b ready=%b, want abcd 0 0", s_dp_a, s_dp_dog, s_in_ready);
      end
      release_result();
   endtask

   task automatic test_round_no_carry();
      int lat;
      run_sample(16'h1234, 1'b1, lat);
      compared++;
      if (lat !== 2) begin
         mismatched++;
         $display("[TB] FAIL round_latency: got %0d, want 2", lat);
      end
      compared++;
      if (s_out_data !== 16'h1300 || s_out_ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL round_data: got %h/%b, want 1300/0", s_out_data, s_out_ovf);
      end
      release_result();
   endtask

   task automatic test_carry();
      int lat;
      run_sample(16'h0F55, 1'b1, lat);
      compared++;
      if (lat !== 3) begin
         mismatched++;
         $display("[TB] FAIL carry_latency: got %0d, want 3", lat);
      end
      compared++;
      if (s_out_data !== 16'h1000 || s_out_ovf !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL carry_data_sat: got %h/%b, want 1000/0", s_out_data, s_out_ovf);
      end
      compared++;
      if (w_out_data !== 16'h1000 || w_out_ovf !== 1'b0 || w_out_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL carry_data_wrap: got %h/%b v=%b, want 1000/0 v=1", w_out_data, w_out_ovf, w_out_valid);
      end
      release_result();
   endtask

   task automatic test_carry_out();
      int lat;
      run_sample(16'hFF00, 1'b1, lat);
      compared++;
      if (lat !== 3) begin
         mismatched++;
         $display("[TB] FAIL ovf_latency: got %0d, want 3", lat);
      end
      compared++;
      if (s_out_data !== 16'hFFFF || s_out_ovf !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL ovf_sat: got %h/%b, want ffff/1", s_out_data, s_out_ovf);
      end
      compared++;
      if (w_out_data !== 16'h0000 || w_out_ovf !== 1'b1 || w_out_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL ovf_wrap: got %h/%b v=%b, want 0000/1 v=1", w_out_data, w_out_ovf, w_out_valid);
      end
      release_result();
   endtask

   task automatic test_hold_stall();
      int lat;
      int bad;
      run_sample(16'h4321, 1'b0, lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (s_out_valid !== 1'b1 || s_out_data !== 16'h4321 || s_in_ready !== 1'b0) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("[TB] FAIL hold_stable: %0d unstable cycles, want 0 (last v=%b d=%h r=%b)", bad, s_out_valid, s_out_data, s_in_ready);
      end
      release_result();
      compared++;
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL hold_release: valid=%b ready=%b, want 0 1", s_out_valid, s_in_ready);
      end
   endtask

   task automatic test_reset_in_hold();
      int lat;
      int seen;
      run_sample(16'h5555, 1'b0, lat);
      compared++;
      if (s_out_valid !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rst_hold_reach: valid=%b, want 1", s_out_valid);
      end
      rst_n = 1'b0;
      tick();
      compared++;
      if (s_out_valid !== 1'b0 || s_out_data !== 16'h0000 || s_in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL rst_hold_clear: valid=%b data=%h ready=%b, want 0 0000 0", s_out_valid, s_out_data, s_in_ready);
      end
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (s_out_valid !== 1'b0) seen++;
      end
      compared++;
      if (seen != 0 || s_in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL rst_hold_idle: stale valid cycles=%0d ready=%b, want 0 1", seen, s_in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      int bad;
      // No carry: one result every 3 cycles.
      in_data = 16'h0100; in_round = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      pulses = 0; bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (s_out_valid === 1'b1) begin
            pulses++;
            if (s_out_data !== 16'h0100) bad++;
         end
      end
      compared++;
      if (pulses != 4 || bad != 0) begin
         mismatched++;
         $display("[TB] FAIL b2b_plain: %0d results (%0d bad), want 4 (0 bad)", pulses, bad);
      end
      // With carry: one result every 4 cycles.
      in_data = 16'h0F00; in_round = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      pulses = 0; bad = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (s_out_valid === 1'b1) begin
            pulses++;
            if (s_out_data !== 16'h1000) bad++;
         end
      end
      compared++;
      if (pulses != 3 || bad != 0) begin
         mismatched++;
         $display("[TB] FAIL b2b_carry: %0d results (%0d bad), want 3 (0 bad)", pulses, bad);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      out_ready = 1'b0;
   endtask

   task automatic test_stats();
      int lat;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         run_sample(16'hFF00, 1'b1, lat);
         release_result();
      end
`ifdef ROUND_STATS_EN
      compared++;
      if (s_stat_rnd !== 2'd3 || s_stat_ovf !== 2'd3) begin
         mismatched++;
         $display("[TB] FAIL stats_sat: rnd=%0d ovf=%0d, want 3 3", s_stat_rnd, s_stat_ovf);
      end
      compared++;
      if (w_stat_rnd !== 2'd3 || w_stat_ovf !== 2'd3) begin
         mismatched++;
         $display("[TB] FAIL stats_wrap_inst: rnd=%0d ovf=%0d, want 3 3", w_stat_rnd, w_stat_ovf);
      end
`else
      compared++;
      if (s_stat_rnd !== '0 || s_stat_ovf !== '0 || w_stat_rnd !== '0 || w_stat_ovf !== '0) begin
         mismatched++;
         $display("[TB] FAIL stats_off: rnd=%0d ovf=%0d, want 0 0", s_stat_rnd, s_stat_ovf);
      end
`endif
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      in_data    = 16'h0000;
      in_round   = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      test_reset();
      test_pass_through();
      test_round_no_carry();
      test_carry();
      test_carry_out();
      test_hold_stall();
      test_reset_in_hold();
      test_back_to_back();
      test_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
